// File: rtl/ndp_test_sequencer.sv
// Stimulus sequencer for the NDP_unit array: reads per-test vectors, streams K steps,
// waits for completion under a watchdog and tallies pass/fail/timeout (optional mismatch log: NDP_SEQ_MISMATCH_LOG_EN).
module ndp_test_sequencer #(
    parameter int WIDTH      = 16,
    parameter int ARR_HEIGHT = 4,
    parameter int ARR_WIDTH  = 4,
    parameter int SYS_HEIGHT = 1,
    parameter int SYS_WIDTH  = 64,
    parameter int K_MAX      = 16,
    parameter int TEST_W     = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                                                   clk,
    input  logic                                                   reset,
    input  logic                                                   start,
    input  logic [TEST_W-1:0]                                      num_tests,
    input  logic [$clog2(K_MAX+1)-1:0]                             k_len,
    output logic                                                   mem_rd_en,
    output logic [TEST_W-1:0]                                      mem_test_idx,
    output logic [$clog2(K_MAX)-1:0]                               mem_step_idx,
    input  logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0]                 mem_a_data,
    input  logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]                   mem_b_data,
    input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] mem_r_data,
    output logic                                                   dut_reset,
    output logic [SYS_HEIGHT*ARR_HEIGHT*WIDTH-1:0]                 dut_in_a,
    output logic [SYS_WIDTH*ARR_WIDTH*WIDTH-1:0]                   dut_in_b,
    output logic                                                   dut_in_done_flag,
    input  logic                                                   dut_calc_done_flag,
    input  logic [SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH-1:0] dut_out_c,
`ifdef NDP_SEQ_MISMATCH_LOG_EN
    output logic                                                   mismatch_valid,
    output logic [TEST_W-1:0]                                      mismatch_test,
    output logic [$clog2(SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH)-1:0] mismatch_lane,
    output logic [WIDTH-1:0]                                       mismatch_exp,
    output logic [WIDTH-1:0]                                       mismatch_act,
`endif
    output logic                                                   busy,
    output logic                                                   done,
    output logic [TEST_W-1:0]                                      pass_count,
    output logic [TEST_W-1:0]                                      fail_count,
    output logic [TEST_W-1:0]                                      timeout_count
);
    localparam int AW    = SYS_HEIGHT * ARR_HEIGHT * WIDTH;
    localparam int BW    = SYS_WIDTH * ARR_WIDTH * WIDTH;
    localparam int NELEM = SYS_HEIGHT * ARR_HEIGHT * SYS_WIDTH * ARR_WIDTH;
    localparam int RW    = NELEM * WIDTH;
    localparam int KW    = $clog2(K_MAX + 1);
    localparam int SW    = $clog2(K_MAX);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_RST, S_FEED, S_FLAG, S_WAIT, S_CHECK, S_NEXT} state_t;

    state_t            state_q, state_d;
    logic [TEST_W-1:0] test_q, test_d, num_q, num_d;
    logic [KW-1:0]     k_q, k_d, k_clamp;
    logic [SW-1:0]     step_q, step_d;
    logic [TW-1:0]     wd_q, wd_d;
    logic              rd_vld_q, rd_vld_d, rd_first_q, rd_first_d;
    logic [AW-1:0]     in_a_q, in_a_d;
    logic [BW-1:0]     in_b_q, in_b_d;
    logic [RW-1:0]     exp_q, exp_d;
    logic              eq_q, eq_d, flag_q, flag_d, dut_reset_q, dut_reset_d, done_q, done_d;
    logic [TEST_W-1:0] pass_q, pass_d, fail_q, fail_d, tmo_q, tmo_d;

    function automatic logic [TEST_W-1:0] sat_inc(input logic [TEST_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

`ifdef NDP_SEQ_MISMATCH_LOG_EN
    localparam int LW = $clog2(NELEM);
    logic              mm_vld_q, mm_vld_d;
    logic [TEST_W-1:0] mm_test_q, mm_test_d;
    logic [LW-1:0]     mm_lane_q, mm_lane_d, mm_lane_c;
    logic [WIDTH-1:0]  mm_exp_q, mm_exp_d, mm_exp_c, mm_act_q, mm_act_d, mm_act_c;

    // Scan downward so the lowest differing element is the one left standing.
    always_comb begin
        mm_lane_c = '0;
        mm_exp_c  = '0;
        mm_act_c  = '0;
        for (int i = NELEM - 1; i >= 0; i--) begin
            if (dut_out_c[i*WIDTH +: WIDTH] != exp_q[i*WIDTH +: WIDTH]) begin
                mm_lane_c = LW'(i);
                mm_exp_c  = exp_q[i*WIDTH +: WIDTH];
                mm_act_c  = dut_out_c[i*WIDTH +: WIDTH];
            end
        end
    end
`endif

    always_comb begin
        state_d    = state_q;
        test_d     = test_q;
        num_d      = num_q;
        k_d        = k_q;
        step_d     = step_q;
        wd_d       = wd_q;
        in_a_d     = in_a_q;
        in_b_d     = in_b_q;
        exp_d      = exp_q;
        eq_d       = eq_q;
        flag_d     = flag_q;
        done_d     = 1'b0;
        pass_d     = pass_q;
        fail_d     = fail_q;
        tmo_d      = tmo_q;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
        mm_vld_d   = mm_vld_q;
        mm_test_d  = mm_test_q;
        mm_lane_d  = mm_lane_q;
        mm_exp_d   = mm_exp_q;
        mm_act_d   = mm_act_q;
`endif
        k_clamp    = (k_len == '0) ? KW'(1) : (k_len > KW'(K_MAX)) ? KW'(K_MAX) : k_len;
        rd_vld_d   = (state_q == S_FEED);
        rd_first_d = (state_q == S_FEED) && (step_q == '0);

        // Memory returns data one cycle after the strobe; registering it here
        // puts step s on the array inputs two cycles after its read.
        if (rd_vld_q) begin
            in_a_d = mem_a_data;
            in_b_d = mem_b_data;
        end
        if (rd_first_q) exp_d = mem_r_data;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pass_d = '0;
                    fail_d = '0;
                    tmo_d  = '0;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
                    mm_vld_d  = 1'b0;
                    mm_test_d = '0;
                    mm_lane_d = '0;
                    mm_exp_d  = '0;
                    mm_act_d  = '0;
`endif
                    if (num_tests != '0) begin
                        num_d   = num_tests;
                        k_d     = k_clamp;
                        test_d  = '0;
                        state_d = S_RST;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_RST: begin
                step_d  = '0;
                state_d = S_FEED;
            end
            S_FEED: begin
                if (KW'(step_q) == k_q - KW'(1)) begin
                    step_d  = '0;
                    state_d = S_FLAG;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            // Two drain cycles let the last step reach the array before the flag.
            S_FLAG: begin
                if (step_q[0]) begin
                    step_d  = '0;
                    wd_d    = '0;
                    flag_d  = 1'b1;
                    state_d = S_WAIT;
                end else begin
                    step_d = step_q + 1'b1;
                end
            end
            S_WAIT: begin
                if (dut_calc_done_flag) begin
                    eq_d    = (dut_out_c == exp_q);
                    state_d = S_CHECK;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
                    if ((dut_out_c != exp_q) && !mm_vld_q) begin
                        mm_vld_d  = 1'b1;
                        mm_test_d = test_q;
                        mm_lane_d = mm_lane_c;
                        mm_exp_d  = mm_exp_c;
                        mm_act_d  = mm_act_c;
                    end
`endif
                end else if (wd_q == TW'(TIMEOUT - 1)) begin
                    tmo_d   = sat_inc(tmo_q);
                    state_d = S_NEXT;
                end else begin
                    wd_d = wd_q + 1'b1;
                end
            end
            S_CHECK: begin
                if (eq_q) pass_d = sat_inc(pass_q);
                else      fail_d = sat_inc(fail_q);
                state_d = S_NEXT;
            end
            S_NEXT: begin
                test_d = test_q + 1'b1;
                flag_d = 1'b0;
                if (test_q + 1'b1 == num_q) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_RST;
                end
            end
            default: state_d = S_IDLE;
        endcase

        dut_reset_d = (state_d == S_RST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            test_q      <= '0;
            num_q       <= '0;
            k_q         <= '0;
            step_q      <= '0;
            wd_q        <= '0;
            rd_vld_q    <= 1'b0;
            rd_first_q  <= 1'b0;
            in_a_q      <= '0;
            in_b_q      <= '0;
            exp_q       <= '0;
            eq_q        <= 1'b0;
            flag_q      <= 1'b0;
            dut_reset_q <= 1'b1;
            done_q      <= 1'b0;
            pass_q      <= '0;
            fail_q      <= '0;
            tmo_q       <= '0;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
            mm_vld_q    <= 1'b0;
            mm_test_q   <= '0;
            mm_lane_q   <= '0;
            mm_exp_q    <= '0;
            mm_act_q    <= '0;
`endif
        end else begin
            state_q     <= state_d;
            test_q      <= test_d;
            num_q       <= num_d;
            k_q         <= k_d;
            step_q      <= step_d;
            wd_q        <= wd_d;
            rd_vld_q    <= rd_vld_d;
            rd_first_q  <= rd_first_d;
            in_a_q      <= in_a_d;
            in_b_q      <= in_b_d;
            exp_q       <= exp_d;
            eq_q        <= eq_d;
            flag_q      <= flag_d;
            dut_reset_q <= dut_reset_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_q      <= fail_d;
            tmo_q       <= tmo_d;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
            mm_vld_q    <= mm_vld_d;
            mm_test_q   <= mm_test_d;
            mm_lane_q   <= mm_lane_d;
            mm_exp_q    <= mm_exp_d;
            mm_act_q    <= mm_act_d;
`endif
        end
    end

    assign mem_rd_en        = (state_q == S_FEED);
    assign mem_test_idx     = test_q;
    assign mem_step_idx     = step_q;
    assign dut_reset        = dut_reset_q;
    assign dut_in_a         = in_a_q;
    assign dut_in_b         = in_b_q;
    assign dut_in_done_flag = flag_q;
    assign busy             = (state_q != S_IDLE);
    assign done             = done_q;
    assign pass_count       = pass_q;
    assign fail_count       = fail_q;
    assign timeout_count    = tmo_q;
`ifdef NDP_SEQ_MISMATCH_LOG_EN
    assign mismatch_valid   = mm_vld_q;
    assign mismatch_test    = mm_test_q;
    assign mismatch_lane    = mm_lane_q;
    assign mismatch_exp     = mm_exp_q;
    assign mismatch_act     = mm_act_q;
`endif
endmodule

// File: doc/ndp_test_sequencer.md
Name: ndp_test_sequencer

Overview:
- Synthesizable, self-checking stimulus sequencer for the NDP_unit systolic array.
- Per test: reads A-column/B-row slices and the expected result from external synchronous vector memories, streams K steps into the array, raises in_done_flag, waits for calc_done_flag under a watchdog, compares out_c and accumulates pass/fail/timeout statistics.
- Successor of the fixed-size behavioural bench: runtime inner dimension (k_len), runtime test count, timeout recovery, on-chip counters.

Parameters:
- WIDTH, 16, element width in bits
- ARR_HEIGHT, 4, PE rows per array
- ARR_WIDTH, 4, PE columns per array
- SYS_HEIGHT, 1, arrays stacked vertically
- SYS_WIDTH, 64, arrays side by side
- K_MAX, 16, maximum inner dimension (steps per test)
- TEST_W, 8, width of test index/count
- TIMEOUT, 1024, max cycles in WAIT before declaring timeout

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; begins a run when idle
- num_tests  in  TEST_W  tests in run, sampled on start
- k_len  in  $clog2(K_MAX+1)  inner dimension, sampled on start
- mem_rd_en  out  1  vector memory read strobe
- mem_test_idx  out  TEST_W  test index for read
- mem_step_idx  out  $clog2(K_MAX)  step index for read
- mem_a_data  in  SYS_HEIGHT*ARR_HEIGHT*WIDTH  A column slice, valid 1 cycle after mem_rd_en
- mem_b_data  in  SYS_WIDTH*ARR_WIDTH*WIDTH  B row slice, same timing
- mem_r_data  in  SYS_HEIGHT*ARR_HEIGHT*SYS_WIDTH*ARR_WIDTH*WIDTH  expected result, same timing
- dut_reset  out  1  reset to NDP_unit
- dut_in_a / dut_in_b  out  widths as mem_a_data / mem_b_data  array inputs
- dut_in_done_flag  out  1  input-complete flag
- dut_calc_done_flag  in  1  array result valid
- dut_out_c  in  width of mem_r_data  array result
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at run end
- pass_count / fail_count / timeout_count  out  TEST_W each  statistics

Behaviour:
- Reset (async, immediate): state IDLE; dut_reset=1; dut_in_a, dut_in_b, dut_in_done_flag, mem_rd_en, mem indices, busy, done, all counters = 0.
- Release: dut_reset falls to 0 on the first clk edge in IDLE.
- IDLE: start with num_tests!=0 → clear counters, latch num_tests/k_len, test=0, go RST.
  - num_tests==0 → done pulse next cycle, counters cleared, stay IDLE.
  - start while busy is ignored.
- k_len clamping: 0 → 1; >K_MAX → K_MAX.
- RST: dut_reset=1 for exactly 1 cycle; dut_in_done_flag=0; go FEED.
- FEED:
  - mem_rd_en=1 with step=0..k_len-1 on consecutive cycles.
  - Each returned A/B slice is registered onto dut_in_a/dut_in_b, so step s is on the DUT inputs for exactly one cycle, 2 cycles after its read.
  - Expected result (mem_r_data at step 0 read) is captured into an internal register.
- FLAG: dut_in_done_flag=1 in the cycle after the last step is presented; held high through WAIT. dut_in_a/dut_in_b hold the last step.
- WAIT:
  - Watchdog counts cycles from entry.
  - dut_calc_done_flag=1 → CHECK.
  - Watchdog reaches TIMEOUT → timeout_count++, then NEXT.
  - Both in the same cycle → completion wins, no timeout counted.
- CHECK: full-width equality of dut_out_c vs captured expected → pass_count++ or fail_count++; go NEXT.
- NEXT: test++; if test==num_tests → IDLE with done pulse and busy=0, else RST.
- busy=1 in every state except IDLE.
- Counters saturate at all-ones.
- Reset mid-run aborts immediately; no partial counts are retained.

Optional Feature:
- Macro: NDP_SEQ_MISMATCH_LOG_EN.
- Enabled: extra outputs mismatch_valid (1), mismatch_test (TEST_W), mismatch_lane ($clog2 of result element count), mismatch_exp/mismatch_act (WIDTH).
  - On the first failing test of a run, record the test index, the lowest mismatching element index, and both values.
  - Outputs hold until the next start or reset; all 0 on reset.
- Disabled: these ports do not exist; no comparison-priority logic is synthesized.

Test Plan:
- Correct DUT model, num_tests=3, k_len=3: three RST/FEED/WAIT cycles → pass=3, fail=0, timeout=0, single done pulse, busy low after.
- Expected memory of test 1, element 5 corrupted: fail=1, pass=2. With macro: mismatch_test=1, mismatch_lane=5, exp/act match the injected values.
- DUT never asserts calc_done, TIMEOUT=16, num_tests=2: each test leaves WAIT after 16 cycles → timeout=2, pass=fail=0, done asserted.
- calc_done asserted in the exact cycle the watchdog expires: pass=1, timeout=0.
- k_len=0 → one step fed; k_len=K_MAX+5 → K_MAX steps fed (count mem_rd_en pulses). num_tests=0 → done next cycle.
- reset asserted in the middle of FEED: outputs at reset values immediately; start during busy ignored; new start after reset runs cleanly.
